mips_control_fsm: RTL and testbench



---
 rtl/mips_control_fsm.sv | 233 +++++++++++++++++++++++
 tb/tb_mips_control_fsm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS controller: sequences each instruction one state per clock and drives every datapath strobe.
// Define MIPS_CTRL_TRAP_EN to trap illegal opcodes/functs in HALT; otherwise they retire as NOPs.
module mips_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Op,
  input  logic [5:0]         Function,
  input  logic               Zero,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemToReg,
  output logic               IRWrite,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               PCSel,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUSrcB,
  output logic [3:0]         ALUCtrl,
  output logic [STATE_W-1:0] state,
  output logic               illegal_op
);

  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMRD    = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWR    = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_RTYPE_EX = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_RTYPE_WB = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_IMM_EX   = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_IMM_WB   = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_JUMP     = STATE_W'(11);
  localparam logic [STATE_W-1:0] S_HALT     = STATE_W'(12);

  // Where an illegal opcode or funct sends the machine.
`ifdef MIPS_CTRL_TRAP_EN
  localparam logic [STATE_W-1:0] S_TRAP = S_HALT;
`else
  localparam logic [STATE_W-1:0] S_TRAP = S_FETCH;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_NOR = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0110;
  localparam logic [3:0] ALU_SUB = 4'b1110;
  localparam logic [3:0] ALU_SLT = 4'b1111;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] next_state;
  logic               is_lw;
  logic               is_sw;
  logic               is_rtype;
  logic               is_beq;
  logic               is_bne;
  logic               is_addi;
  logic               is_slti;
  logic               is_j;
  logic               funct_ok;
  logic [3:0]         funct_alu;

  assign is_lw    = (Op == OP_LW);
  assign is_sw    = (Op == OP_SW);
  assign is_rtype = (Op == OP_RTYPE);
  assign is_beq   = (Op == OP_BEQ);
  assign is_bne   = (Op == OP_BNE);
  assign is_addi  = (Op == OP_ADDI);
  assign is_slti  = (Op == OP_SLTI);
  assign is_j     = (Op == OP_J);

  // R-type funct to ALU operation; unknown functs are flagged and fall back to ADD.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (Function)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b100110: funct_alu = ALU_XOR;
      6'b100111: funct_alu = ALU_NOR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    case (state_q)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        if (is_lw || is_sw)          next_state = S_MEMADR;
        else if (is_rtype)           next_state = S_RTYPE_EX;
        else if (is_beq || is_bne)   next_state = S_BRANCH;
        else if (is_addi || is_slti) next_state = S_IMM_EX;
        else if (is_j)               next_state = S_JUMP;
        else                         next_state = S_TRAP;
      end
      S_MEMADR: begin
        if (is_lw)      next_state = S_MEMRD;
        else if (is_sw) next_state = S_MEMWR;
        else            next_state = S_FETCH;
      end
      S_MEMRD:    next_state = S_MEMWB;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWR:    next_state = S_FETCH;
      S_RTYPE_EX: next_state = funct_ok ? S_RTYPE_WB : S_TRAP;
      S_RTYPE_WB: next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_IMM_EX:   next_state = S_IMM_WB;
      S_IMM_WB:   next_state = S_FETCH;
      S_JUMP:     next_state = S_FETCH;
`ifdef MIPS_CTRL_TRAP_EN
      S_HALT:     next_state = S_HALT;
`else
      S_HALT:     next_state = S_FETCH;
`endif
      default:    next_state = S_FETCH;
    endcase
  end

  // Moore decode of the state, except PCSel in BRANCH which follows Zero directly.
  // Reset forces every output low so no strobe escapes while the state is being re-established.
  always_comb begin
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemToReg   = 1'b0;
    IRWrite    = 1'b0;
    ALUSrcA    = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    PCSel      = 1'b0;
    PCSource   = 2'b00;
    ALUSrcB    = 2'b00;
    ALUCtrl    = ALU_ADD;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCSel   = 1'b1;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_RTYPE_EX: begin
        ALUSrcA = 1'b1;
        ALUCtrl = funct_alu;
      end
      S_RTYPE_WB: begin
        ALUSrcA  = 1'b1;
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        ALUCtrl  = funct_alu;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUCtrl  = ALU_SUB;
        PCSource = 2'b01;
        PCSel    = (is_beq && Zero) || (is_bne && !Zero);
      end
      S_IMM_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUCtrl = is_slti ? ALU_SLT : ALU_ADD;
      end
      S_IMM_WB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSel    = 1'b1;
        PCSource = 2'b10;
      end
`ifdef MIPS_CTRL_TRAP_EN
      S_HALT: illegal_op = 1'b1;
`endif
      default: ;
    endcase
    if (reset) begin
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemToReg   = 1'b0;
      IRWrite    = 1'b0;
      ALUSrcA    = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 1'b0;
      PCSel      = 1'b0;
      PCSource   = 2'b00;
      ALUSrcB    = 2'b00;
      ALUCtrl    = 4'b0000;
      illegal_op = 1'b0;
    end
  end

  assign state = reset ? '0 : state_q;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed bench for mips_control_fsm: walks each instruction class cycle by cycle against hand-derived outputs.
// Illegal-instruction expectations follow MIPS_CTRL_TRAP_EN when it is defined for the build.
module tb_mips_control_fsm;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Function;
  logic       Zero;
  logic       IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUSrcA, RegWrite, RegDst, PCSel;
  logic [1:0] PCSource;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUCtrl;
  logic [3:0] state;
  logic       illegal_op;
  logic [8:0] strobes;

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] B_IORD   = 9'b100000000;
  localparam logic [8:0] B_MEMRD  = 9'b010000000;
  localparam logic [8:0] B_MEMWR  = 9'b001000000;
  localparam logic [8:0] B_M2R    = 9'b000100000;
  localparam logic [8:0] B_IRW    = 9'b000010000;
  localparam logic [8:0] B_SRCA   = 9'b000001000;
  localparam logic [8:0] B_REGW   = 9'b000000100;
  localparam logic [8:0] B_REGDST = 9'b000000010;
  localparam logic [8:0] B_PCSEL  = 9'b000000001;
  localparam logic [8:0] B_NONE   = 9'b000000000;

  mips_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Function(Function), .Zero(Zero),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
    .PCSel(PCSel), .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl),
    .state(state), .illegal_op(illegal_op)
  );

  assign strobes = {IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUSrcA, RegWrite, RegDst, PCSel};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input int exp_state, input logic [8:0] exp_strb,
                             input logic [1:0] exp_pcsrc, input logic [1:0] exp_srcb,
                             input logic [3:0] exp_alu);
    check_output({tag, ".state"}, 32'(state), 32'(exp_state));
    check_output({tag, ".strobes"}, 32'(strobes), 32'(exp_strb));
    check_output({tag, ".pcsource"}, 32'(PCSource), 32'(exp_pcsrc));
    check_output({tag, ".alusrcb"}, 32'(ALUSrcB), 32'(exp_srcb));
    check_output({tag, ".aluctrl"}, 32'(ALUCtrl), 32'(exp_alu));
    check_output({tag, ".illegal"}, 32'(illegal_op), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check_output({tag, ".state"}, 32'(state), 32'd0);
    check_output({tag, ".strobes"}, 32'(strobes), 32'd0);
    check_output({tag, ".pcsource"}, 32'(PCSource), 32'd0);
    check_output({tag, ".alusrcb"}, 32'(ALUSrcB), 32'd0);
    check_output({tag, ".aluctrl"}, 32'(ALUCtrl), 32'd0);
    check_output({tag, ".illegal"}, 32'(illegal_op), 32'd0);
  endtask

  task automatic check_fetch(input string tag);
    check_cycle(tag, 0, B_MEMRD | B_IRW | B_PCSEL, 2'b00, 2'b01, 4'b0110);
  endtask

  task automatic check_decode(input string tag);
    check_cycle(tag, 1, B_NONE, 2'b00, 2'b11, 4'b0110);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [5:0] op, input logic [5:0] funct, input logic zero);
    Op = op;
    Function = funct;
    Zero = zero;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    apply_stimulus(6'b100011, 6'b000000, 1'b0);
    check_reset("rst_pre_edge");
    step();
    check_reset("rst_cycle1");
    step();
    check_reset("rst_cycle2");
    reset = 1'b0;
    #1;

    // lw: 0,1,2,3,4,0
    check_fetch("lw_fetch");
    step(); check_decode("lw_decode");
    step(); check_cycle("lw_memadr", 2, B_SRCA, 2'b00, 2'b10, 4'b0110);
    step(); check_cycle("lw_memrd", 3, B_IORD | B_MEMRD, 2'b00, 2'b00, 4'b0110);
    step(); check_cycle("lw_memwb", 4, B_M2R | B_REGW, 2'b00, 2'b00, 4'b0110);
    step(); check_fetch("lw_done");

    // sub: 0,1,6,7,0
    apply_stimulus(6'b000000, 6'b100010, 1'b0);
    step(); check_decode("sub_decode");
    step(); check_cycle("sub_ex", 6, B_SRCA, 2'b00, 2'b00, 4'b1110);
    step(); check_cycle("sub_wb", 7, B_SRCA | B_REGDST | B_REGW, 2'b00, 2'b00, 4'b1110);
    step(); check_fetch("sub_done");

    // or
    apply_stimulus(6'b000000, 6'b100101, 1'b0);
    step(); check_decode("or_decode");
    step(); check_cycle("or_ex", 6, B_SRCA, 2'b00, 2'b00, 4'b0001);
    step(); check_cycle("or_wb", 7, B_SRCA | B_REGDST | B_REGW, 2'b00, 2'b00, 4'b0001);
    step(); check_fetch("or_done");

    // beq: PCSel follows Zero inside the BRANCH cycle
    apply_stimulus(6'b000100, 6'b000000, 1'b1);
    step(); check_decode("beq_decode");
    step(); check_cycle("beq_z1", 8, B_SRCA | B_PCSEL, 2'b01, 2'b00, 4'b1110);
    apply_stimulus(6'b000100, 6'b000000, 1'b0);
    check_cycle("beq_z0", 8, B_SRCA, 2'b01, 2'b00, 4'b1110);
    step(); check_fetch("beq_done");

    // bne: inverted sense
    apply_stimulus(6'b000101, 6'b000000, 1'b1);
    step(); check_decode("bne_decode");
    step(); check_cycle("bne_z1", 8, B_SRCA, 2'b01, 2'b00, 4'b1110);
    apply_stimulus(6'b000101, 6'b000000, 1'b0);
    check_cycle("bne_z0", 8, B_SRCA | B_PCSEL, 2'b01, 2'b00, 4'b1110);
    step(); check_fetch("bne_done");

    // sw: 0,1,2,5,0
    apply_stimulus(6'b101011, 6'b000000, 1'b0);
    step(); check_decode("sw_decode");
    step(); check_cycle("sw_memadr", 2, B_SRCA, 2'b00, 2'b10, 4'b0110);
    step(); check_cycle("sw_memwr", 5, B_IORD | B_MEMWR, 2'b00, 2'b00, 4'b0110);
    step(); check_fetch("sw_done");

    // j: 0,1,11,0
    apply_stimulus(6'b000010, 6'b000000, 1'b0);
    step(); check_decode("j_decode");
    step(); check_cycle("j_jump", 11, B_PCSEL, 2'b10, 2'b00, 4'b0110);
    step(); check_fetch("j_done");

    // addi and slti
    apply_stimulus(6'b001000, 6'b000000, 1'b0);
    step(); check_decode("addi_decode");
    step(); check_cycle("addi_ex", 9, B_SRCA, 2'b00, 2'b10, 4'b0110);
    step(); check_cycle("addi_wb", 10, B_REGW, 2'b00, 2'b00, 4'b0110);
    step(); check_fetch("addi_done");
    apply_stimulus(6'b001010, 6'b000000, 1'b0);
    step(); check_decode("slti_decode");
    step(); check_cycle("slti_ex", 9, B_SRCA, 2'b00, 2'b10, 4'b1111);
    step(); check_cycle("slti_wb", 10, B_REGW, 2'b00, 2'b00, 4'b0110);
    step(); check_fetch("slti_done");

    // reset in MEMRD aborts the load before its writeback
    apply_stimulus(6'b100011, 6'b000000, 1'b0);
    step(); check_decode("abort_decode");
    step(); check_cycle("abort_memadr", 2, B_SRCA, 2'b00, 2'b10, 4'b0110);
    step(); check_cycle("abort_memrd", 3, B_IORD | B_MEMRD, 2'b00, 2'b00, 4'b0110);
    reset = 1'b1;
    #1;
    check_reset("abort_in_reset");
    step();
    check_reset("abort_reset_edge");
    reset = 1'b0;
    #1;
    check_fetch("abort_fetch");

    // illegal opcode
    apply_stimulus(6'b111111, 6'b000000, 1'b0);
    step(); check_decode("badop_decode");
    step();
`ifdef MIPS_CTRL_TRAP_EN
    for (int i = 0; i < 11; i++) begin
      check_output("badop_halt.state", 32'(state), 32'd12);
      check_output("badop_halt.strobes", 32'(strobes), 32'd0);
      check_output("badop_halt.illegal", 32'(illegal_op), 32'd1);
      step();
    end
    reset = 1'b1;
    #1;
    check_reset("badop_reset");
    step();
    reset = 1'b0;
    #1;
`endif
    check_fetch("badop_fetch");

    // illegal funct
    apply_stimulus(6'b000000, 6'b000001, 1'b0);
    step(); check_decode("badfn_decode");
    step(); check_cycle("badfn_ex", 6, B_SRCA, 2'b00, 2'b00, 4'b0110);
    step();
`ifdef MIPS_CTRL_TRAP_EN
    for (int i = 0; i < 11; i++) begin
      check_output("badfn_halt.state", 32'(state), 32'd12);
      check_output("badfn_halt.strobes", 32'(strobes), 32'd0);
      check_output("badfn_halt.illegal", 32'(illegal_op), 32'd1);
      step();
    end
    reset = 1'b1;
    #1;
    check_reset("badfn_reset");
    step();
    reset = 1'b0;
    #1;
`endif
    check_fetch("badfn_fetch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
